fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the dispatch unit.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to dispatch over a valid/ready handshake.
- Handles redirects (branch/jump resolution) by flushing buffered and in-flight fetches.

Parameters:
CORE, 0, core index; used only in simulation report output
DATA_WIDTH, 32, instruction width
ADDR_WIDTH, 32, PC/address width
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; leave IDLE and begin fetching
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  redirect target (word aligned)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address
imem_rsp_valid  in  1  response valid; responses arrive in request order, >=1 cycle after acceptance
imem_rsp_data  in  DATA_WIDTH  fetched instruction
out_valid  out  1  instruction available to dispatch
out_ready  in  1  dispatch consumes instruction
out_instruction  out  DATA_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  PC of head instruction
fifo_count  out  log2(FIFO_DEPTH)+1  occupied entries
report  in  1  simulation only: $display state, PC and count each cycle; no effect on logic

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, squash=0. All outputs 0 except imem_req_addr=RESET_PC.
- States:
  - IDLE: no requests. start -> RUN. redirect_valid in IDLE loads pc and stays in IDLE.
  - RUN: imem_req_valid=1 iff fifo_count+outstanding < FIFO_DEPTH (credit rule; every response is guaranteed a slot). imem_req_addr=pc.
  - FLUSH: imem_req_valid=0 until squash==0, then -> RUN.
- Request handshake: on imem_req_valid && imem_req_ready, pc<=pc+4 (modulo 2^ADDR_WIDTH) and outstanding increments.
- Responses:
  - Each imem_rsp_valid decrements outstanding.
  - If squash>0: data is dropped and squash decrements.
  - Otherwise data is pushed to the FIFO together with its PC. The PC comes from an internal PC tag queue of depth FIFO_DEPTH, written at request acceptance.
- Output: out_valid = FIFO non-empty. The head is combinational from FIFO storage. Pop on out_valid && out_ready. Push and pop in the same cycle are both performed, including when the FIFO is full.
- Redirect (RUN or FLUSH):
  - Next cycle: FIFO empty, pc=redirect_pc, squash=outstanding after this cycle's accept/response updates.
  - State -> FLUSH if that squash value is >0, else RUN.
  - A response arriving in the redirect cycle is dropped.
  - A request accepted in the redirect cycle is counted as outstanding and squashed.
  - An output handshake in the redirect cycle completes; dispatch keeps that instruction.
- Minimum latency: request accepted at cycle N, response at N+1, out_valid at N+2.
- Overflow/underflow cannot occur. The bench asserts fifo_count+outstanding <= FIFO_DEPTH and that outstanding never underflows.
- start while in RUN/FLUSH is ignored.

Test Plan:
- Reset: hold reset=0, toggle inputs -> out_valid=0, imem_req_valid=0, fifo_count=0, imem_req_addr=0; release, no start -> remains idle, no requests.
- Streaming: start, imem_req_ready=1, 1-cycle memory returning addr^0xA5A50000, out_ready=1 -> requests 0x0,0x4,0x8,...; first out_valid 2 cycles after first accept; out_pc/out_instruction pairs match in order, one per cycle.
- Backpressure: out_ready=0 -> exactly 4 requests issued, fifo_count=4, imem_req_valid=0; raise out_ready -> instructions 0x0..0xC drain in order, fetching resumes at 0x10.
- Redirect with in-flight: 3-cycle memory latency, 2 outstanding, redirect to 0x100 -> both stale responses dropped, FIFO empty, next out_pc=0x100, then 0x104.
- Simultaneous: redirect in same cycle as a response and an output pop -> popped instruction delivered once, response dropped, no stale instruction afterwards.
- Wrap and async reset: redirect to 0xFFFFFFFC -> next request address 0x00000000; assert reset mid-stream (between clock edges) -> outputs clear immediately, restart at RESET_PC after start.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/response channel and dispatch
//                output channel of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [ADDR_WIDTH-1:0] imem_req_addr;
   logic                  imem_rsp_valid;
   logic [DATA_WIDTH-1:0] imem_rsp_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_instruction;
   logic [ADDR_WIDTH-1:0] out_pc;

   // Fetch-unit side: issues memory requests and presents instructions
   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

   // Environment side: instruction memory and dispatch
   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues credit-limited
//                word requests, buffers PC-tagged instructions in a FIFO and
//                flushes buffered and in-flight fetches on redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int                    CORE       = 0,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  wire logic                        clock,
   input  wire logic                        reset,
   input  wire logic                        start,
   input  wire logic                        redirect_valid,
   input  wire logic [ADDR_WIDTH-1:0]       redirect_pc,
   fetch_unit_if.master                     bus,
   output      logic [$clog2(FIFO_DEPTH):0] fifo_count,
   input  wire logic                        report
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]            state_q,       state_d;
   logic [ADDR_WIDTH-1:0] pc_q,          pc_d;
   logic [CNT_W-1:0]      count_q,       count_d;
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;
   logic [CNT_W-1:0]      squash_q,      squash_d;
   logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
   logic [PTR_W-1:0]      tag_rd_q,      tag_rd_d;
   logic [PTR_W-1:0]      tag_wr_q,      tag_wr_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] tag_pc_q    [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] tag_pc_d    [FIFO_DEPTH];

   logic [CNT_W:0] occupancy;
   logic           credit_ok;
   logic           req_fire;
   logic           rsp_fire;
   logic           push;
   logic           pop;
   logic           redirect_act;

   // report and CORE only steer simulation printouts elsewhere; no logic uses them
   logic unused_report;
   assign unused_report = report ^ (CORE != 0);

   // Every buffered entry plus every in-flight request holds a FIFO slot,
   // so a response always finds room.
   assign occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
   assign credit_ok = occupancy < CREDIT_MAX;

   assign bus.imem_req_valid  = (state_q == S_RUN) && credit_ok;
   assign bus.imem_req_addr   = pc_q;
   assign bus.out_valid       = (count_q != '0);
   assign bus.out_instruction = fifo_data_q[rd_ptr_q];
   assign bus.out_pc          = fifo_pc_q[rd_ptr_q];
   assign fifo_count          = count_q;

   assign req_fire     = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_fire     = bus.imem_rsp_valid;
   assign pop          = bus.out_valid && bus.out_ready;
   assign redirect_act = redirect_valid && (state_q != S_IDLE);
   // A response is kept only when it is not stale and no redirect discards it
   assign push         = rsp_fire && (squash_q == '0) && !redirect_act;

   // Next-state: PC/tag queue on accept, FIFO push/pop, squash and FSM, redirect last
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      squash_d      = squash_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      tag_rd_d      = tag_rd_q;
      tag_wr_d      = tag_wr_q;
      fifo_data_d   = fifo_data_q;
      fifo_pc_d     = fifo_pc_q;
      tag_pc_d      = tag_pc_q;

      if (req_fire) begin
         pc_d               = pc_q + ADDR_WIDTH'(4);
         tag_pc_d[tag_wr_q] = pc_q;
         tag_wr_d           = tag_wr_q + PTR_W'(1);
      end

      // Every response, kept or squashed, retires its PC tag
      if (rsp_fire) begin
         tag_rd_d = tag_rd_q + PTR_W'(1);
         if (squash_q != '0) begin
            squash_d = squash_q - CNT_W'(1);
         end
      end

      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

      if (push) begin
         fifo_data_d[wr_ptr_q] = bus.imem_rsp_data;
         fifo_pc_d[wr_ptr_q]   = tag_pc_q[tag_rd_q];
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            state_d = S_RUN;
         end
         S_FLUSH: begin
            if (squash_q == '0) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Redirect empties the buffer; everything still in flight becomes stale
      if (redirect_act) begin
         pc_d     = redirect_pc;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         squash_d = outstanding_d;
         state_d  = (outstanding_d != '0) ? S_FLUSH : S_RUN;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         squash_q      <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         tag_rd_q      <= '0;
         tag_wr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
            tag_pc_q[i]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         squash_q      <= squash_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         tag_rd_q      <= tag_rd_d;
         tag_wr_q      <= tag_wr_d;
         fifo_data_q   <= fifo_data_d;
         fifo_pc_q     <= fifo_pc_d;
         tag_pc_q      <= tag_pc_d;
      end
   end

endmodule
`default_nettype wire
